order_table_sched: RTL and testbench
====================================

ORDER_TABLE_SCHED -- requirements
Module: order_table_sched

Interface
REQ-001 SHALL have parameter ORDER_TABLE_SIZE, default 1024, order table depth; ADDR_W = $clog2(ORDER_TABLE_SIZE).
REQ-002 SHALL have parameter RD_LATENCY, default 2, table read latency in cycles (1..4).
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 64, maximum cycles a read-modify-write lock is held.
REQ-004 SHALL have ports:
- clk  in  1  clock; one clock; all logic on posedge clk.
- reset  in  1  reset; synchronous, active-high.
- exch_req_valid / exch_req_ready  in / out  1  exchange requester handshake.
- exch_req_address  in  ADDR_W  table address.
- exch_req_wren  in  1  1=write, 0=read.
- exch_req_lock  in  1  read opens an RMW lock.
- exch_req_data  in  order_entry_t  write data.
- exch_rsp_valid / exch_rsp_data  out  1 / order_entry_t  read response.
- cli_req_*, cli_rsp_*  same set for the client requester.
- tbl_address / tbl_data / tbl_rden / tbl_wren  out  ADDR_W / order_entry_t / 1 / 1  table port.
- tbl_rddata  in  order_entry_t  valid RD_LATENCY cycles after tbl_rden.
- lock_timeout  out  1  one-cycle pulse on forced lock release.

Function
REQ-005 SHALL accept a request when req_valid && req_ready; at most one requester granted per cycle.
REQ-006 SHALL drive tbl_* combinationally from the granted request in the grant cycle; tbl_rden/tbl_wren SHALL be 0 when nothing is granted.
REQ-007 SHALL arbitrate round-robin: the requester not granted most recently wins a tie; after reset, exchange has priority.
REQ-008 SHALL pulse <r>_rsp_valid exactly RD_LATENCY cycles after that requester's read grant, with rsp_data = tbl_rddata; writes produce no response.
REQ-009 SHALL track in-flight reads with a RD_LATENCY-deep owner-tag shift register; responses SHALL stay in order, with no back-pressure on rsp.
REQ-010 SHALL implement FSM IDLE -> LOCKED on a granted read with req_lock=1, recording the owner and lock address.
REQ-011 In LOCKED, only the owner SHALL get req_ready; the other requester's ready SHALL be 0.
REQ-012 SHALL go LOCKED -> IDLE on the owner's granted write to the lock address, in the cycle after that grant.
REQ-013 An owner request to another address while LOCKED SHALL be granted without releasing the lock; a further read with lock=1 SHALL NOT nest or restart the timer.
REQ-014 SHALL count cycles in LOCKED; at count == LOCK_TIMEOUT it SHALL pulse lock_timeout and return to IDLE without issuing a write.
REQ-015 Simultaneous valid with a write to an address that has an in-flight read: the write SHALL be granted normally; the read SHALL return pre-write data (no hazard logic).

Reset
REQ-016 reset SHALL force: FSM IDLE, timer 0, tag pipeline empty, round-robin pointer to exchange, all rsp_valid/tbl_rden/tbl_wren/lock_timeout 0.
REQ-017 Reads in flight when reset asserts SHALL be discarded; no rsp_valid in the RD_LATENCY cycles after reset deasserts.
REQ-018 req_ready SHALL be 0 while reset is asserted.

Configuration
REQ-019 With ORDER_TABLE_SCHED_EXCH_PRIORITY_EN defined, exchange SHALL win every IDLE tie (strict priority); without it, REQ-007 round-robin SHALL apply. Lock behaviour SHALL be unchanged either way.

Structure
REQ-020 order_entry_t SHALL come from package lse_order_table; a new package order_table_sched_pkg SHALL hold the FSM state enum and requester-id enum.
REQ-021 Sub-module order_table_rr_arb (2-way round-robin with priority override) SHALL be instantiated once.

Verification
REQ-022 Exch read addr 5 at cycle 10, table holds price=0x64 -> tbl_rden at 10; exch_rsp_valid at 12 (RD_LATENCY=2) with price=0x64.
REQ-023 Both valid every cycle, reads, 8 cycles -> grants alternate E,C,E,C...; exactly 4 rsp each.
REQ-024 Cli locked read addr 9, exch valid meanwhile -> exch_req_ready=0 until cli writes addr 9; exch granted the next cycle.
REQ-025 Cli locked read, no write for 64 cycles -> lock_timeout pulse at cycle 64; exch granted the next cycle.
REQ-026 reset asserted 1 cycle after a read grant -> no rsp_valid ever for that read; FSM IDLE.
REQ-027 With ORDER_TABLE_SCHED_EXCH_PRIORITY_EN, both valid for 4 cycles -> 4 exch grants, 0 cli grants.

Source files
------------

// File: rtl/lse_order_table.sv
// Order table entry format shared by the table and everything that reads or writes it.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package lse_order_table;

  typedef struct packed {
    logic [15:0] order_id;
    logic [31:0] price;
    logic [23:0] qty;
    logic        side;    // 0 = bid, 1 = ask
    logic        active;
  } order_entry_t;

endpackage

// File: rtl/order_table_sched_pkg.sv
// Shared types for the order table scheduler: lock FSM state and requester ids.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package order_table_sched_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Requester ids double as the bit index into the 2-bit request/grant vectors.
  typedef enum logic {
    REQ_EXCH = 1'b0,
    REQ_CLI  = 1'b1
  } req_id_e;

endpackage

// File: rtl/order_table_rr_arb.sv
// 2-way round-robin arbiter with an exchange-priority override.
// Latency: grant is combinational from req_i; pointer updates on the grant edge.
// Backpressure: none; a loser simply sees no grant and retries.
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   req_i[1:0]   requests, bit REQ_EXCH / bit REQ_CLI
//   prio_i       when set, exchange wins a tie regardless of the pointer
//   gnt_o[1:0]   one-hot (or zero) grant
module order_table_rr_arb
  import order_table_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  // Last requester granted; reset to client so exchange wins the first tie.
  req_id_e last_q, last_d;

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      if (prio_i || (last_q == REQ_CLI)) begin
        gnt_o = 2'b01;
      end else begin
        gnt_o = 2'b10;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_o[REQ_EXCH]) begin
      last_d = REQ_EXCH;
    end else if (gnt_o[REQ_CLI]) begin
      last_d = REQ_CLI;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= REQ_CLI;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/order_table_sched.sv
// Order table scheduler: arbitrates exchange and client requesters onto one table port, with RMW locks.
// Latency: table port driven in the grant cycle; read response RD_LATENCY cycles after the read grant.
// Backpressure: req_ready gates acceptance (lock owner only while locked); responses cannot be stalled.
//
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   exch_req_* / exch_rsp_*      exchange requester (valid/ready request, fire-and-forget response)
//   cli_req_*  / cli_rsp_*       client requester, same shape
//   tbl_address/data/rden/wren   table port, driven combinationally from the granted request
//   tbl_rddata                   table read data, valid RD_LATENCY cycles after tbl_rden
//   lock_timeout                 one-cycle pulse when a lock is forcibly released
//
// Build option: define ORDER_TABLE_SCHED_EXCH_PRIORITY_EN to make exchange win every
// unlocked tie (strict priority) instead of round-robin. Lock behaviour is identical.
module order_table_sched
  import lse_order_table::*;
  import order_table_sched_pkg::*;
#(
  parameter  int ORDER_TABLE_SIZE = 1024,
  parameter  int RD_LATENCY       = 2,
  parameter  int LOCK_TIMEOUT     = 64,
  localparam int ADDR_W           = $clog2(ORDER_TABLE_SIZE)
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              exch_req_valid,
  output logic              exch_req_ready,
  input  logic [ADDR_W-1:0] exch_req_address,
  input  logic              exch_req_wren,
  input  logic              exch_req_lock,
  input  order_entry_t      exch_req_data,
  output logic              exch_rsp_valid,
  output order_entry_t      exch_rsp_data,

  input  logic              cli_req_valid,
  output logic              cli_req_ready,
  input  logic [ADDR_W-1:0] cli_req_address,
  input  logic              cli_req_wren,
  input  logic              cli_req_lock,
  input  order_entry_t      cli_req_data,
  output logic              cli_rsp_valid,
  output order_entry_t      cli_rsp_data,

  output logic [ADDR_W-1:0] tbl_address,
  output order_entry_t      tbl_data,
  output logic              tbl_rden,
  output logic              tbl_wren,
  input  order_entry_t      tbl_rddata,

  output logic              lock_timeout
);

  localparam int TMR_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  // timer_q holds (cycles spent in LOCKED) - 1, so this value marks the LOCK_TIMEOUT-th cycle.
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(LOCK_TIMEOUT - 1);

  // Lock FSM state and context
  lock_state_e       state_q, state_d;
  req_id_e           owner_q, owner_d;
  logic [ADDR_W-1:0] lock_addr_q, lock_addr_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  // In-flight read tags: valid bit and owner (1 = client) per pipeline stage.
  logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LATENCY-1:0] tag_cli_q, tag_cli_d;

  // Arbitration
  logic [1:0]        elig;      // requesters allowed to compete this cycle
  logic [1:0]        arb_req;
  logic [1:0]        gnt;
  logic              exch_prio;
  logic              timeout_hit;

  // Granted request, muxed
  req_id_e           gnt_id;
  logic              gnt_any;
  logic [ADDR_W-1:0] sel_addr;
  order_entry_t      sel_data;
  logic              sel_wren;
  logic              sel_lock;
  logic              grant_rd;
  logic              grant_wr;

  //--------------------------------------------------------------------------
  // Arbitration
  //--------------------------------------------------------------------------
  assign arb_req = {cli_req_valid, exch_req_valid} & elig;

`ifdef ORDER_TABLE_SCHED_EXCH_PRIORITY_EN
  assign exch_prio = (state_q == ST_IDLE);
`else
  assign exch_prio = 1'b0;
`endif

  order_table_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_i  (arb_req),
    .prio_i (exch_prio),
    .gnt_o  (gnt)
  );

  // Ready is eligibility minus losing to the other requester, so valid && ready == grant.
  assign exch_req_ready = elig[REQ_EXCH] & ~gnt[REQ_CLI];
  assign cli_req_ready  = elig[REQ_CLI]  & ~gnt[REQ_EXCH];

  assign gnt_any  = |gnt;
  assign gnt_id   = gnt[REQ_CLI] ? REQ_CLI : REQ_EXCH;
  assign sel_addr = gnt[REQ_CLI] ? cli_req_address : exch_req_address;
  assign sel_data = gnt[REQ_CLI] ? cli_req_data    : exch_req_data;
  assign sel_wren = gnt[REQ_CLI] ? cli_req_wren    : exch_req_wren;
  assign sel_lock = gnt[REQ_CLI] ? cli_req_lock    : exch_req_lock;
  assign grant_rd = gnt_any & ~sel_wren;
  assign grant_wr = gnt_any &  sel_wren;

  //--------------------------------------------------------------------------
  // Table port
  //--------------------------------------------------------------------------
  assign tbl_address = sel_addr;
  assign tbl_data    = sel_data;
  assign tbl_rden    = grant_rd;
  assign tbl_wren    = grant_wr;

  //--------------------------------------------------------------------------
  // Lock FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= REQ_EXCH;
      lock_addr_q <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lock_addr_q <= lock_addr_d;
      timer_q     <= timer_d;
    end
  end

  assign timeout_hit = (state_q == ST_LOCKED) && (timer_q == TMO_LAST);

  //--------------------------------------------------------------------------
  // Lock FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lock_addr_d = lock_addr_q;
    timer_d     = '0;
    case (state_q)
      ST_IDLE: begin
        if (grant_rd && sel_lock) begin
          state_d     = ST_LOCKED;
          owner_d     = gnt_id;
          lock_addr_d = sel_addr;
        end
      end
      ST_LOCKED: begin
        // A further locked read by the owner falls through here: no nesting, timer keeps running.
        timer_d = timer_q + TMR_W'(1);
        if (timeout_hit ||
            (grant_wr && (gnt_id == owner_q) && (sel_addr == lock_addr_q))) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // Lock FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    elig         = 2'b00;
    lock_timeout = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: begin
          elig = 2'b11;
        end
        ST_LOCKED: begin
          elig                 = 2'b00;
          elig[owner_q]        = 1'b1;
          lock_timeout         = timeout_hit;
        end
        default: elig = 2'b00;
      endcase
    end
  end

  //--------------------------------------------------------------------------
  // In-flight read tag pipeline
  //--------------------------------------------------------------------------
  always_comb begin
    tag_vld_d    = '0;
    tag_cli_d    = '0;
    tag_vld_d[0] = grant_rd;
    tag_cli_d[0] = gnt[REQ_CLI];
    for (int i = 1; i < RD_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_cli_d[i] = tag_cli_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld_q <= '0;
      tag_cli_q <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_cli_q <= tag_cli_d;
    end
  end

  // The last stage lines up with tbl_rddata; the owner bit steers it to one requester.
  assign exch_rsp_valid = ~reset & tag_vld_q[RD_LATENCY-1] & ~tag_cli_q[RD_LATENCY-1];
  assign cli_rsp_valid  = ~reset & tag_vld_q[RD_LATENCY-1] &  tag_cli_q[RD_LATENCY-1];
  assign exch_rsp_data  = tbl_rddata;
  assign cli_rsp_data   = tbl_rddata;

endmodule

// File: tb/tb_order_table_sched.sv
module tb_order_table_sched;
  import lse_order_table::*;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              exch_req_valid, exch_req_ready, exch_req_wren, exch_req_lock;
  logic [ADDR_W-1:0] exch_req_address;
  order_entry_t      exch_req_data, exch_rsp_data;
  logic              exch_rsp_valid;
  logic              cli_req_valid, cli_req_ready, cli_req_wren, cli_req_lock;
  logic [ADDR_W-1:0] cli_req_address;
  order_entry_t      cli_req_data, cli_rsp_data;
  logic              cli_rsp_valid;
  logic [ADDR_W-1:0] tbl_address;
  order_entry_t      tbl_data, tbl_rddata;
  logic              tbl_rden, tbl_wren;
  logic              lock_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  logic tb_init = 1'b0;

  always #5 clk = ~clk;

  order_table_sched dut (
    .clk(clk), .reset(reset),
    .exch_req_valid(exch_req_valid), .exch_req_ready(exch_req_ready),
    .exch_req_address(exch_req_address), .exch_req_wren(exch_req_wren),
    .exch_req_lock(exch_req_lock), .exch_req_data(exch_req_data),
    .exch_rsp_valid(exch_rsp_valid), .exch_rsp_data(exch_rsp_data),
    .cli_req_valid(cli_req_valid), .cli_req_ready(cli_req_ready),
    .cli_req_address(cli_req_address), .cli_req_wren(cli_req_wren),
    .cli_req_lock(cli_req_lock), .cli_req_data(cli_req_data),
    .cli_rsp_valid(cli_rsp_valid), .cli_rsp_data(cli_rsp_data),
    .tbl_address(tbl_address), .tbl_data(tbl_data), .tbl_rden(tbl_rden),
    .tbl_wren(tbl_wren), .tbl_rddata(tbl_rddata), .lock_timeout(lock_timeout)
  );

  // Initial table content: price 0x100+addr, except addr 5 holds price 0x64.
  function automatic order_entry_t mk_entry(input int a);
    order_entry_t e;
    e          = '0;
    e.order_id = 16'(a);
    e.price    = (a == 5) ? 32'h64 : 32'h100 + 32'(a);
    e.qty      = 24'(a);
    e.active   = 1'b1;
    return e;
  endfunction

  // Table stub with a 2-cycle read pipeline.
  order_entry_t mem [1024];
  order_entry_t rd_p0, rd_p1;
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= mk_entry(i);
    end else if (tbl_wren) begin
      mem[tbl_address] <= tbl_data;
    end
    rd_p0 <= mem[tbl_address];
    rd_p1 <= rd_p0;
  end
  assign tbl_rddata = rd_p1;

  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    exch_req_valid = 0; exch_req_wren = 0; exch_req_lock = 0;
    exch_req_address = '0; exch_req_data = '0;
    cli_req_valid = 0; cli_req_wren = 0; cli_req_lock = 0;
    cli_req_address = '0; cli_req_data = '0;
  endtask

  task automatic apply_reset;
    idle_inputs();
    reset = 1;
    next_cyc();
    next_cyc();
    reset = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1; tb_init = 1;
    exch_req_valid = 1; exch_req_address = 10'd1;
    cli_req_valid = 1;  cli_req_address = 10'd2;
    repeat (3) next_cyc();
    #3;
    n_cmp++; if (exch_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_exch_ready got=%b exp=0", exch_req_ready); end
    n_cmp++; if (cli_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cli_ready got=%b exp=0", cli_req_ready); end
    n_cmp++; if (tbl_rden !== 1'b0 || tbl_wren !== 1'b0) begin n_bad++; $display("FAIL rst_tbl_en got=%b%b exp=00", tbl_rden, tbl_wren); end
    n_cmp++; if (exch_rsp_valid !== 1'b0 || cli_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp got=%b%b exp=00", exch_rsp_valid, cli_rsp_valid); end
    n_cmp++; if (lock_timeout !== 1'b0) begin n_bad++; $display("FAIL rst_lock_timeout got=%b exp=0", lock_timeout); end
    next_cyc();
    reset = 0; tb_init = 0;
    #3;
    n_cmp++; if (exch_req_ready !== 1'b1 || cli_req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_first_tie got=%b%b exp=10", exch_req_ready, cli_req_ready); end
    n_cmp++; if (tbl_address !== 10'd1 || tbl_rden !== 1'b1) begin n_bad++; $display("FAIL rst_first_addr got=%0d/%b exp=1/1", tbl_address, tbl_rden); end
    next_cyc();
    idle_inputs();
  endtask

  task automatic test_single_read;
    order_entry_t wd;
    logic seen;
    apply_reset();
    exch_req_valid = 1; exch_req_address = 10'd5;
    #3;
    n_cmp++; if (tbl_rden !== 1'b1 || tbl_address !== 10'd5 || exch_req_ready !== 1'b1) begin n_bad++; $display("FAIL rd_grant got=rden%b addr%0d rdy%b exp=1/5/1", tbl_rden, tbl_address, exch_req_ready); end
    next_cyc(); idle_inputs(); #3;
    n_cmp++; if (exch_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_early_rsp got=%b exp=0", exch_rsp_valid); end
    next_cyc(); #3;
    n_cmp++; if (exch_rsp_valid !== 1'b1 || exch_rsp_data.price !== 32'h64) begin n_bad++; $display("FAIL rd_rsp got=%b/%h exp=1/64", exch_rsp_valid, exch_rsp_data.price); end
    n_cmp++; if (cli_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_owner got=%b exp=0", cli_rsp_valid); end
    next_cyc(); #3;
    n_cmp++; if (exch_rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_rsp_pulse got=%b exp=0", exch_rsp_valid); end
    // Write: table port carries the data, no response follows.
    next_cyc();
    wd = mk_entry(6); wd.price = 32'hABCD;
    exch_req_valid = 1; exch_req_wren = 1; exch_req_address = 10'd6; exch_req_data = wd;
    #3;
    n_cmp++; if (tbl_wren !== 1'b1 || tbl_rden !== 1'b0 || tbl_data !== wd) begin n_bad++; $display("FAIL wr_port got=wren%b rden%b price%h exp=1/0/abcd", tbl_wren, tbl_rden, tbl_data.price); end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      next_cyc(); idle_inputs(); #3;
      seen |= exch_rsp_valid | cli_rsp_valid;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL wr_no_rsp got=%b exp=0", seen); end
  endtask

  task automatic test_round_robin;
    int n_e, n_c;
    logic exp_e, exp_re, exp_rc;
    int exp_addr, exp_price;
    n_e = 0; n_c = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        exch_req_valid = 1; exch_req_address = 10'(10 + i);
        cli_req_valid = 1;  cli_req_address = 10'(20 + i);
      end else begin
        idle_inputs();
      end
      #3;
      if (i < 8) begin
        exp_e = (i % 2 == 0);
        exp_addr = exp_e ? 10 + i : 20 + i;
        n_cmp++; if (exch_req_ready !== exp_e || cli_req_ready !== !exp_e) begin n_bad++; $display("FAIL rr_grant_%0d got=%b%b exp=%b%b", i, exch_req_ready, cli_req_ready, exp_e, !exp_e); end
        n_cmp++; if (tbl_address !== 10'(exp_addr)) begin n_bad++; $display("FAIL rr_addr_%0d got=%0d exp=%0d", i, tbl_address, exp_addr); end
      end
      if (i >= 2) begin
        exp_re = ((i - 2) % 2 == 0);
        exp_rc = !exp_re;
        exp_price = 32'h100 + (exp_re ? 10 + i - 2 : 20 + i - 2);
        n_cmp++; if (exch_rsp_valid !== exp_re || cli_rsp_valid !== exp_rc) begin n_bad++; $display("FAIL rr_rsp_%0d got=%b%b exp=%b%b", i, exch_rsp_valid, cli_rsp_valid, exp_re, exp_rc); end
        n_cmp++; if (tbl_rddata.price !== 32'(exp_price)) begin n_bad++; $display("FAIL rr_data_%0d got=%h exp=%h", i, tbl_rddata.price, exp_price); end
      end
      if (exch_rsp_valid === 1'b1) n_e++;
      if (cli_rsp_valid === 1'b1) n_c++;
      next_cyc();
    end
    n_cmp++; if (n_e != 4 || n_c != 4) begin n_bad++; $display("FAIL rr_rsp_count got=%0d/%0d exp=4/4", n_e, n_c); end
  endtask

  task automatic test_lock;
    order_entry_t wd;
    apply_reset();
    cli_req_valid = 1; cli_req_lock = 1; cli_req_address = 10'd9;
    #3;
    n_cmp++; if (cli_req_ready !== 1'b1 || tbl_rden !== 1'b1) begin n_bad++; $display("FAIL lk_grant got=%b/%b exp=1/1", cli_req_ready, tbl_rden); end
    for (int i = 1; i <= 4; i++) begin
      next_cyc(); idle_inputs();
      exch_req_valid = 1; exch_req_address = 10'd11;
      #3;
      n_cmp++; if (exch_req_ready !== 1'b0 || tbl_rden !== 1'b0) begin n_bad++; $display("FAIL lk_block_%0d got=%b/%b exp=0/0", i, exch_req_ready, tbl_rden); end
      if (i == 2) begin
        n_cmp++; if (cli_rsp_valid !== 1'b1 || cli_rsp_data.price !== 32'h109) begin n_bad++; $display("FAIL lk_rsp got=%b/%h exp=1/109", cli_rsp_valid, cli_rsp_data.price); end
      end
    end
    // Owner touches another address: granted, lock held.
    next_cyc();
    cli_req_valid = 1; cli_req_lock = 0; cli_req_address = 10'd3;
    #3;
    n_cmp++; if (cli_req_ready !== 1'b1 || exch_req_ready !== 1'b0 || tbl_address !== 10'd3) begin n_bad++; $display("FAIL lk_other_addr got=%b%b/%0d exp=10/3", cli_req_ready, exch_req_ready, tbl_address); end
    next_cyc();
    wd = mk_entry(9); wd.price = 32'h999;
    cli_req_wren = 1; cli_req_address = 10'd9; cli_req_data = wd;
    #3;
    n_cmp++; if (cli_req_ready !== 1'b1 || tbl_wren !== 1'b1 || exch_req_ready !== 1'b0) begin n_bad++; $display("FAIL lk_release_wr got=%b/%b/%b exp=1/1/0", cli_req_ready, tbl_wren, exch_req_ready); end
    next_cyc();
    cli_req_valid = 0; cli_req_wren = 0;
    #3;
    n_cmp++; if (exch_req_ready !== 1'b1 || tbl_rden !== 1'b1) begin n_bad++; $display("FAIL lk_after_release got=%b/%b exp=1/1", exch_req_ready, tbl_rden); end
    next_cyc();
    idle_inputs();
  endtask

  task automatic test_timeout;
    logic exp_to, exp_rdy;
    apply_reset();
    cli_req_valid = 1; cli_req_lock = 1; cli_req_address = 10'd9;
    #3;
    n_cmp++; if (cli_req_ready !== 1'b1) begin n_bad++; $display("FAIL to_grant got=%b exp=1", cli_req_ready); end
    for (int k = 1; k <= 65; k++) begin
      next_cyc(); idle_inputs();
      exch_req_valid = 1; exch_req_address = 10'd12;
      if (k == 30) begin
        // Re-lock by the owner must not nest or restart the timer.
        cli_req_valid = 1; cli_req_lock = 1; cli_req_address = 10'd9;
      end
      #3;
      exp_to  = (k == 64);
      exp_rdy = (k == 65);
      n_cmp++; if (lock_timeout !== exp_to) begin n_bad++; $display("FAIL to_pulse_%0d got=%b exp=%b", k, lock_timeout, exp_to); end
      n_cmp++; if (exch_req_ready !== exp_rdy) begin n_bad++; $display("FAIL to_exch_ready_%0d got=%b exp=%b", k, exch_req_ready, exp_rdy); end
      if (k == 30) begin
        n_cmp++; if (cli_req_ready !== 1'b1) begin n_bad++; $display("FAIL to_relock got=%b exp=1", cli_req_ready); end
      end
      if (k == 64) begin
        n_cmp++; if (tbl_wren !== 1'b0) begin n_bad++; $display("FAIL to_no_write got=%b exp=0", tbl_wren); end
      end
    end
    next_cyc();
    idle_inputs();
  endtask

  task automatic test_reset_inflight;
    logic seen;
    apply_reset();
    cli_req_valid = 1; cli_req_lock = 1; cli_req_address = 10'd9;
    #3;
    n_cmp++; if (cli_req_ready !== 1'b1) begin n_bad++; $display("FAIL ri_grant got=%b exp=1", cli_req_ready); end
    next_cyc(); idle_inputs();
    reset = 1; exch_req_valid = 1;
    #3;
    n_cmp++; if (exch_req_ready !== 1'b0) begin n_bad++; $display("FAIL ri_ready_in_reset got=%b exp=0", exch_req_ready); end
    next_cyc();
    reset = 0; exch_req_valid = 0;
    #3;
    n_cmp++; if (exch_req_ready !== 1'b1) begin n_bad++; $display("FAIL ri_fsm_idle got=%b exp=1", exch_req_ready); end
    seen = cli_rsp_valid | exch_rsp_valid;
    for (int i = 0; i < 4; i++) begin
      next_cyc(); #3;
      seen |= cli_rsp_valid | exch_rsp_valid;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL ri_no_rsp got=%b exp=0", seen); end
  endtask

  task automatic test_back_to_back;
    order_entry_t wd;
    apply_reset();
    wd = mk_entry(40); wd.price = 32'h777;
    exch_req_valid = 1; exch_req_address = 10'd40;
    cli_req_valid = 1; cli_req_wren = 1; cli_req_address = 10'd40; cli_req_data = wd;
    #3;
    n_cmp++; if (exch_req_ready !== 1'b1 || cli_req_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_first got=%b%b exp=10", exch_req_ready, cli_req_ready); end
    next_cyc();
    exch_req_valid = 0;
    #3;
    n_cmp++; if (cli_req_ready !== 1'b1 || tbl_wren !== 1'b1) begin n_bad++; $display("FAIL b2b_write got=%b/%b exp=1/1", cli_req_ready, tbl_wren); end
    next_cyc(); idle_inputs(); #3;
    n_cmp++; if (exch_rsp_valid !== 1'b1 || exch_rsp_data.price !== 32'h128) begin n_bad++; $display("FAIL b2b_old_data got=%b/%h exp=1/128", exch_rsp_valid, exch_rsp_data.price); end
    next_cyc();
    exch_req_valid = 1; exch_req_address = 10'd40;
    next_cyc(); idle_inputs();
    next_cyc(); #3;
    n_cmp++; if (exch_rsp_valid !== 1'b1 || exch_rsp_data.price !== 32'h777) begin n_bad++; $display("FAIL b2b_new_data got=%b/%h exp=1/777", exch_rsp_valid, exch_rsp_data.price); end
    next_cyc();
  endtask

  task automatic test_priority;
    int g_e, g_c, x_e, x_c;
    g_e = 0; g_c = 0;
`ifdef ORDER_TABLE_SCHED_EXCH_PRIORITY_EN
    x_e = 4; x_c = 0;
`else
    x_e = 2; x_c = 2;
`endif
    apply_reset();
    // One exchange-only grant first so the round-robin pointer favours client.
    exch_req_valid = 1; exch_req_address = 10'd1;
    next_cyc();
    for (int i = 0; i < 4; i++) begin
      exch_req_valid = 1; exch_req_address = 10'(50 + i);
      cli_req_valid = 1;  cli_req_address = 10'(60 + i);
      #3;
      if (exch_req_valid && exch_req_ready) g_e++;
      if (cli_req_valid && cli_req_ready) g_c++;
      next_cyc();
    end
    idle_inputs();
    n_cmp++; if (g_e != x_e || g_c != x_c) begin n_bad++; $display("FAIL prio_grants got=%0d/%0d exp=%0d/%0d", g_e, g_c, x_e, x_c); end
    repeat (3) next_cyc();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_timeout();
    test_reset_inflight();
    test_back_to_back();
    test_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
